// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, requests words from instruction memory,
// presents the fetched word until commit, and halts on misaligned target or memory timeout.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcsel,
    input  logic [31:0] alu_result,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        misalign_err,
    output logic        fetch_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   ins_reg, ins_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic          misalign_reg, misalign_next;
    logic          timeout_reg, timeout_next;
    logic [31:0]   target;
    logic          unused_alu_lsb;

    assign unused_alu_lsb = alu_result[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            ins_reg      <= NOP_INS;
            wait_reg     <= '0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ins_reg      <= ins_next;
            wait_reg     <= wait_next;
            misalign_reg <= misalign_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ins_next      = ins_reg;
        wait_next     = wait_reg;
        misalign_next = misalign_reg;
        timeout_next  = timeout_reg;
        // Bit 0 is always dropped (JALR semantics); bit 1 decides alignment.
        target = pcsel ? {alu_result[31:1], 1'b0} : pc_reg + 32'd4;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    ins_next   = imem_rdata;
                    wait_next  = '0;
                    state_next = VALID;
                end else if (wait_reg == CW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = HALT;
                end else begin
                    wait_next = wait_reg + CW'(1);
                end
            end
            VALID: begin
                if (advance) begin
                    if (target[1]) begin
                        misalign_next = 1'b1;
                        state_next    = HALT;
                    end else begin
                        pc_next    = target;
                        ins_next   = NOP_INS;
                        state_next = FETCH;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign imem_req      = (state_reg == FETCH);
    assign ins_valid     = (state_reg == VALID);
    assign imem_addr     = {pc_reg[31:2], 2'b00};
    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + 32'd4;
    assign ins           = ins_reg;
    assign misalign_err  = misalign_reg;
    assign fetch_timeout = timeout_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential flow, redirects, misalignment,
// timeout boundary, PC wrap and reset during an outstanding fetch.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, pcsel, advance, imem_ready;
    logic [31:0] alu_result, imem_rdata;
    logic        imem_req, ins_valid, misalign_err, fetch_timeout;
    logic [31:0] imem_addr, pc, pc_plus4, ins;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0), .NOP_INS(32'h0000_0013), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .pcsel(pcsel), .alu_result(alu_result),
        .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
        .pc_plus4(pc_plus4), .ins(ins), .ins_valid(ins_valid),
        .misalign_err(misalign_err), .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, required finish within 50000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at the start of a FETCH cycle; memory answers after 'delay' idle cycles.
    task automatic fetch(input logic [31:0] addr, input int delay);
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, addr);
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            step();
            check("fetch_wait_req", {31'b0, imem_req}, 32'd1);
        end
        imem_ready = 1'b1;
        imem_rdata = mem_word(addr);
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        check("valid_flag", {31'b0, ins_valid}, 32'd1);
        check("valid_ins", ins, mem_word(addr));
        check("valid_req_low", {31'b0, imem_req}, 32'd0);
        check("valid_pc", pc, addr);
        $display("fetch addr=%h ins=%h pc_plus4=%h", addr, ins, pc_plus4);
    endtask

    task automatic commit(input logic sel, input logic [31:0] alu);
        advance    = 1'b1;
        pcsel      = sel;
        alu_result = alu;
        step();
        advance    = 1'b0;
        pcsel      = 1'b0;
        alu_result = 32'h0;
        $display("commit pcsel=%0d alu=%h -> pc=%h", sel, alu, pc);
    endtask

    task automatic reset_to_fetch();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; pcsel = 1'b0; advance = 1'b0; imem_ready = 1'b0;
        alu_result = 32'h0; imem_rdata = 32'h0;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_ins", ins, 32'h0000_0013);
        check("rst_valid", {31'b0, ins_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst_timeout", {31'b0, fetch_timeout}, 32'd0);

        // Sequential flow
        rst_n = 1'b1;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        fetch(32'h0, 2);
        check("pc_plus4_0", pc_plus4, 32'h4);
        commit(1'b0, 32'h0);
        check("seq_pc4", pc, 32'h4);
        check("seq_ins_nop", ins, 32'h0000_0013);
        fetch(32'h4, 2);
        commit(1'b0, 32'h0);
        check("seq_pc8", pc, 32'h8);
        fetch(32'h8, 2);

        // Redirect with bit 0 dropped
        commit(1'b1, 32'h0000_0101);
        check("jal_pc", pc, 32'h100);
        check("jal_pc_plus4", pc_plus4, 32'h104);
        check("jal_addr", imem_addr, 32'h100);
        fetch(32'h100, 0);

        // Misaligned target halts and keeps pc
        commit(1'b1, 32'h0000_0102);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        check("mis_pc", pc, 32'h100);
        check("mis_req", {31'b0, imem_req}, 32'd0);
        check("mis_valid", {31'b0, ins_valid}, 32'd0);
        advance = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_ins", ins, mem_word(32'h100));
        end
        advance = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;

        // Wrap
        reset_to_fetch();
        check("rst_clears_mis", {31'b0, misalign_err}, 32'd0);
        fetch(32'h0, 1);
        commit(1'b1, 32'hFFFF_FFFD);
        check("wrap_pc_top", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        fetch(32'hFFFF_FFFC, 0);
        commit(1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_noerr", {31'b0, misalign_err}, 32'd0);
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        fetch(32'h0, 0);
        commit(1'b1, 32'h0000_0201);
        check("redir_200", pc, 32'h200);

        // Reset while FETCH with ready on the reset edge
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("mfr_ins", ins, 32'h0000_0013);
        check("mfr_valid", {31'b0, ins_valid}, 32'd0);
        check("mfr_req", {31'b0, imem_req}, 32'd0);
        check("mfr_pc", pc, 32'h0);
        rst_n = 1'b1;
        step();
        check("mfr_idle_ignored", ins, 32'h0000_0013);
        imem_ready = 1'b0; imem_rdata = 32'h0;

        // Timeout: 16 FETCH cycles with no ready
        for (int i = 0; i < 15; i++) step();
        check("to_req_cycle16", {31'b0, imem_req}, 32'd1);
        check("to_not_yet", {31'b0, fetch_timeout}, 32'd0);
        step();
        check("to_flag", {31'b0, fetch_timeout}, 32'd1);
        check("to_req_low", {31'b0, imem_req}, 32'd0);
        check("to_valid", {31'b0, ins_valid}, 32'd0);
        $display("timeout after 16 FETCH cycles: fetch_timeout=%0d", fetch_timeout);

        // Ready on the 16th cycle wins over timeout
        reset_to_fetch();
        for (int i = 0; i < 15; i++) step();
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ready = 1'b0;
        check("late_valid", {31'b0, ins_valid}, 32'd1);
        check("late_ins", ins, 32'h1234_5678);
        check("late_notimeout", {31'b0, fetch_timeout}, 32'd0);
        $display("ready on 16th FETCH cycle: ins=%h", ins);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
